bsg_axil_fifo_master: RTL
=========================

# bsg_axil_fifo_master

AXI-Lite master that drives one memory-mapped FIFO slot from the fabric side, acting as the initiator for a slave exposing ISR/TDFV/TDR/RDFO/RDR/RLR registers at `axil_base_addr_p`. Outbound words from a valid/ready port are written to the slot's transmit register, with optional ISR-based confirmation. Inbound words are drained by polling RLR, then reading RDR. It lets on-chip logic (e.g. a loopback or management agent) exercise the host-FIFO path in simulation and in-system.

## Interface
- `axil_base_addr_p`, "inv": byte base of the slot; register offsets are added to it.
- `rlr_words_p`, 4: 32-bit words read from RDR per non-zero RLR result.
- `poll_gap_p`, 16: idle cycles after an RLR=0 before the next RX poll; ≥1.
- `axil_mosi_bus_width_lp`, `` `bsg_axil_mosi_bus_width(1) ``: outbound AXI-Lite bundle width.
- `axil_miso_bus_width_lp`, `` `bsg_axil_miso_bus_width(1) ``: inbound AXI-Lite bundle width.
- `clk_i` in 1: the single clock.
- `reset_i` in 1: asynchronous, active-high reset.
- `m_axil_bus_o` out mosi_w: awaddr/awvalid, wdata/wstrb/wvalid, bready, araddr/arvalid, rready.
- `m_axil_bus_i` in miso_w: awready, wready, bresp/bvalid, arready, rdata/rresp/rvalid.
- `tx_v_i` in 1: outbound word valid. Must hold, with data stable, until `tx_yumi_o`.
- `tx_data_i` in 32: outbound word.
- `tx_yumi_o` out 1: one-cycle pulse; the word is consumed.
- `rx_v_o` out 1: inbound word valid.
- `rx_data_o` out 32: inbound word.
- `rx_ready_i` in 1: consumer ready.
- `err_o` out 1: sticky; set on any non-zero bresp/rresp.

## Operation
- Offsets: ISR 0x0, TDR 0x10, RLR 0x24, RDR 0x20. wstrb is always 4'hF.
- Bus FSM: B_IDLE, B_AW, B_W, B_B, B_AR, B_R. Only one transaction is outstanding.
- Write phases are strictly serial:
  - B_AW: awvalid is held until awready.
  - B_W: wvalid is held until wready.
  - B_B: bready=1 until bvalid.
- Read phases:
  - B_AR: arvalid is held until arready.
  - B_R: rready=1 until rvalid; rdata is captured on that handshake.
- Job FSM states: J_IDLE, J_TX_CLR, J_TX_DATA, J_TX_CHK, J_RX_LEN, J_RX_DATA, J_RX_OUT, J_GAP.
- Arbitration in J_IDLE is round-robin between a TX job (`tx_v_i`=1) and an RX job (always eligible). The last-served job has lowest priority. Reset prefers TX.
- TX job (check enabled):
  - J_TX_CLR writes ISR=0.
  - J_TX_DATA writes `tx_data_i` to TDR.
  - J_TX_CHK reads ISR. If bit27=1, pulse `tx_yumi_o` and go to J_IDLE. If bit27=0, return to J_TX_CLR and retry the same word.
- RX job:
  - J_RX_LEN reads RLR. If 0, go to J_GAP, count `poll_gap_p` cycles, then J_IDLE. If non-zero, load word counter = `rlr_words_p` and go to J_RX_DATA.
  - J_RX_DATA reads RDR into the output register, then goes to J_RX_OUT.
  - J_RX_OUT holds `rx_v_o`=1 until `rx_ready_i`. Then decrement the counter; go to J_RX_DATA if non-zero, else J_IDLE.
- The next RDR read is never issued before the previous word is handed off.
- Error handling: any bresp/rresp ≠ 0 sets `err_o` and aborts the job.
  - An aborted TX job still pulses `tx_yumi_o`; the word is dropped.
  - An aborted RX job goes to J_GAP; remaining words are abandoned.

## Timing
- Reset values: all valids/readies, `tx_yumi_o`, `rx_v_o`, and `err_o` are 0; addresses/data are 0. Both FSMs are idle, the arbiter prefers TX, and the gap counter is 0.
- All bus outputs come from registers; there is no combinational path from `m_axil_bus_i` to `m_axil_bus_o`.
- Each bus phase takes at least 1 cycle. A bus transaction starts the cycle after the job state is entered.
- TX critical path: J_IDLE→AW→W→B (≥3 cycles per write, plus slave latency).
- `tx_yumi_o` asserts in the cycle after the final bvalid (no-check) or rvalid (check) handshake.
- `rx_v_o` rises the cycle after the RDR rvalid handshake. Back-to-back `rx_ready_i` high gives one word per RDR transaction.
- A reset asserted mid-transaction drops all valids asynchronously and abandons the transaction. The slave must be reset in the same domain.
- `tx_v_i` deasserting before `tx_yumi_o` is illegal (assertion in simulation).

## Configuration
- Macro: `BSG_AXIL_FIFO_MASTER_TX_CHECK_EN`.
- Defined: the TX job runs CLR/DATA/CHK with ISR retry, as described above.
- Undefined: J_TX_CLR and J_TX_CHK are removed. TX is a single TDR write, and `tx_yumi_o` pulses after the bvalid handshake (OKAY or error).

## Test plan
- TX, check enabled, slave accepts: tx_data 0xDEADBEEF → writes ISR=0, then TDR=0xDEADBEEF, then ISR read returns 0x0800_0000 → one `tx_yumi_o` pulse; the slave FIFO holds the word.
- TX retry: the first ISR read returns 0, the second returns bit27 set → exactly 2 TDR writes of the same word, then one yumi.
- RX drain: slave RLR=16, RDR supplies 1,2,3,4, and `rx_ready_i` is low for 3 cycles on word 2 → `rx_data_o` is 1,2,3,4 in order. The third RDR read is not issued until word 2 is accepted.
- Empty poll: RLR=0 → no RDR read, and the next RLR read is at least `poll_gap_p`=16 cycles later.
- Decode error: `axil_base_addr_p` is unmapped so bresp=2'b11 → `err_o`=1 and stays set; the tx word is yumied and the FSM returns to idle.
- Reset during B_W with wvalid=1 → wvalid is 0 during reset. After release the first transaction is a fresh job from J_IDLE (TX preferred).

Source files
------------

// File: rtl/bsg_axil_fifo_master.sv
// AXI-Lite initiator for one memory-mapped FIFO slot (ISR/TDR/RLR/RDR), bridging valid/ready ports.
// Define BSG_AXIL_FIFO_MASTER_TX_CHECK_EN to confirm each TX word through an ISR clear/read loop.
module bsg_axil_fifo_master
  #(parameter logic [31:0] axil_base_addr_p = 32'h0
   ,parameter int rlr_words_p = 4
   ,parameter int poll_gap_p = 16
   ,parameter int axil_mosi_bus_width_lp = 111
   ,parameter int axil_miso_bus_width_lp = 41
   )
  (input  logic                              clk_i
  ,input  logic                              reset_i
  ,output logic [axil_mosi_bus_width_lp-1:0] m_axil_bus_o
  ,input  logic [axil_miso_bus_width_lp-1:0] m_axil_bus_i
  ,input  logic                              tx_v_i
  ,input  logic [31:0]                       tx_data_i
  ,output logic                              tx_yumi_o
  ,output logic                              rx_v_o
  ,output logic [31:0]                       rx_data_o
  ,input  logic                              rx_ready_i
  ,output logic                              err_o
  );

  // Bundle layouts, MSB first
  typedef struct packed {
    logic [31:0] awaddr; logic [2:0] awprot; logic awvalid;
    logic [31:0] wdata;  logic [3:0] wstrb;  logic wvalid;
    logic        bready;
    logic [31:0] araddr; logic [2:0] arprot; logic arvalid;
    logic        rready;
  } mosi_s;

  typedef struct packed {
    logic awready; logic wready;
    logic [1:0] bresp; logic bvalid;
    logic arready;
    logic [31:0] rdata; logic [1:0] rresp; logic rvalid;
  } miso_s;

  typedef enum logic [2:0] {B_IDLE, B_AW, B_W, B_B, B_AR, B_R} bus_e;
  typedef enum logic [2:0] {J_IDLE, J_TX_CLR, J_TX_DATA, J_TX_CHK,
                            J_RX_LEN, J_RX_DATA, J_RX_OUT, J_GAP} job_e;

  localparam logic [31:0] isr_off_lp = 32'h0;
  localparam logic [31:0] tdr_off_lp = 32'h10;
  localparam logic [31:0] rdr_off_lp = 32'h20;
  localparam logic [31:0] rlr_off_lp = 32'h24;
  localparam int gap_w_lp   = $clog2(poll_gap_p + 1);
  localparam int words_w_lp = $clog2(rlr_words_p + 1);
`ifdef BSG_AXIL_FIFO_MASTER_TX_CHECK_EN
  localparam job_e tx_first_lp = J_TX_CLR;
`else
  localparam job_e tx_first_lp = J_TX_DATA;
`endif

  miso_s bus_in;
  mosi_s bus_out;
  assign bus_in = m_axil_bus_i;

  bus_e bus_q;
  job_e job_q;
  logic [31:0] addr_q, wdata_q, rx_data_q;
  logic awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic yumi_q, rx_v_q, err_q, last_tx_q;
  logic [gap_w_lp-1:0]   gap_q;
  logic [words_w_lp-1:0] words_q;

  logic b_done, r_done, resp_err;
  assign b_done   = (bus_q == B_B) && bus_in.bvalid;
  assign r_done   = (bus_q == B_R) && bus_in.rvalid;
  assign resp_err = (b_done && (bus_in.bresp != 2'b00)) || (r_done && (bus_in.rresp != 2'b00));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      bus_q <= B_IDLE;  job_q <= J_IDLE;
      addr_q <= '0;  wdata_q <= '0;  rx_data_q <= '0;
      awvalid_q <= 1'b0; wvalid_q <= 1'b0; bready_q <= 1'b0;
      arvalid_q <= 1'b0; rready_q <= 1'b0;
      yumi_q <= 1'b0; rx_v_q <= 1'b0; err_q <= 1'b0; last_tx_q <= 1'b0;
      gap_q <= '0; words_q <= '0;
    end else begin
      yumi_q <= 1'b0;
      if (resp_err) err_q <= 1'b1;

      // The bus engine launches one transaction per job-state visit, the cycle after entry.
      unique case (bus_q)
        B_IDLE:
          unique case (job_q)
            J_TX_CLR:  begin addr_q <= axil_base_addr_p + isr_off_lp; wdata_q <= '0;
                             awvalid_q <= 1'b1; bus_q <= B_AW; end
            J_TX_DATA: begin addr_q <= axil_base_addr_p + tdr_off_lp; wdata_q <= tx_data_i;
                             awvalid_q <= 1'b1; bus_q <= B_AW; end
            J_TX_CHK:  begin addr_q <= axil_base_addr_p + isr_off_lp; arvalid_q <= 1'b1; bus_q <= B_AR; end
            J_RX_LEN:  begin addr_q <= axil_base_addr_p + rlr_off_lp; arvalid_q <= 1'b1; bus_q <= B_AR; end
            J_RX_DATA: begin addr_q <= axil_base_addr_p + rdr_off_lp; arvalid_q <= 1'b1; bus_q <= B_AR; end
            default: ;
          endcase
        B_AW: if (bus_in.awready) begin awvalid_q <= 1'b0; wvalid_q <= 1'b1; bus_q <= B_W; end
        B_W:  if (bus_in.wready)  begin wvalid_q <= 1'b0; bready_q <= 1'b1; bus_q <= B_B; end
        B_B:  if (bus_in.bvalid)  begin bready_q <= 1'b0; bus_q <= B_IDLE; end
        B_AR: if (bus_in.arready) begin arvalid_q <= 1'b0; rready_q <= 1'b1; bus_q <= B_R; end
        B_R:  if (bus_in.rvalid)  begin rready_q <= 1'b0; bus_q <= B_IDLE; end
        default: bus_q <= B_IDLE;
      endcase

      unique case (job_q)
        J_IDLE:
          if (tx_v_i && !last_tx_q) begin job_q <= tx_first_lp; last_tx_q <= 1'b1; end
          else                      begin job_q <= J_RX_LEN;    last_tx_q <= 1'b0; end
`ifdef BSG_AXIL_FIFO_MASTER_TX_CHECK_EN
        J_TX_CLR:
          if (b_done) begin
            if (resp_err) begin yumi_q <= 1'b1; job_q <= J_IDLE; end
            else job_q <= J_TX_DATA;
          end
        J_TX_DATA:
          if (b_done) begin
            if (resp_err) begin yumi_q <= 1'b1; job_q <= J_IDLE; end
            else job_q <= J_TX_CHK;
          end
        J_TX_CHK:
          if (r_done) begin
            if (resp_err || bus_in.rdata[27]) begin yumi_q <= 1'b1; job_q <= J_IDLE; end
            else job_q <= J_TX_CLR;
          end
`else
        J_TX_DATA:
          if (b_done) begin yumi_q <= 1'b1; job_q <= J_IDLE; end
`endif
        J_RX_LEN:
          if (r_done) begin
            if (resp_err || (bus_in.rdata == 32'h0)) begin
              gap_q <= gap_w_lp'(poll_gap_p); job_q <= J_GAP;
            end else begin
              words_q <= words_w_lp'(rlr_words_p); job_q <= J_RX_DATA;
            end
          end
        J_RX_DATA:
          if (r_done) begin
            if (resp_err) begin gap_q <= gap_w_lp'(poll_gap_p); job_q <= J_GAP; end
            else begin rx_data_q <= bus_in.rdata; rx_v_q <= 1'b1; job_q <= J_RX_OUT; end
          end
        J_RX_OUT:
          if (rx_ready_i) begin
            rx_v_q  <= 1'b0;
            words_q <= words_q - 1'b1;
            job_q   <= (words_q == words_w_lp'(1)) ? J_IDLE : J_RX_DATA;
          end
        J_GAP:
          if (gap_q <= gap_w_lp'(1)) begin gap_q <= '0; job_q <= J_IDLE; end
          else gap_q <= gap_q - 1'b1;
        default: job_q <= J_IDLE;
      endcase
    end
  end

  always_comb begin
    bus_out         = '0;
    bus_out.awaddr  = addr_q;
    bus_out.awvalid = awvalid_q;
    bus_out.wdata   = wdata_q;
    bus_out.wstrb   = 4'hF;
    bus_out.wvalid  = wvalid_q;
    bus_out.bready  = bready_q;
    bus_out.araddr  = addr_q;
    bus_out.arvalid = arvalid_q;
    bus_out.rready  = rready_q;
  end

  assign m_axil_bus_o = bus_out;
  assign tx_yumi_o    = yumi_q;
  assign rx_v_o       = rx_v_q;
  assign rx_data_o    = rx_data_q;
  assign err_o        = err_q;

`ifndef SYNTHESIS
  tx_hold_a: assert property (@(posedge clk_i) disable iff (reset_i)
    (job_q inside {J_TX_CLR, J_TX_DATA, J_TX_CHK}) |-> tx_v_i);
`endif

endmodule
